// File: rtl/regfile_pkg.sv
// Shared integer register-file parameters and the write-back request record.
// Imported by the register file and by its write-back arbiter.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int NUM_WB_REQ = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// i_ptr (wrapping modulo N) receives the single one-hot grant.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic w_found;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      automatic int idx = int'(i_ptr) + i;
      if (idx >= N) idx -= N;
      if (!w_found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Write-back arbiter for the register-file write port plus the busy scoreboard
// that the issue stage consults for RAW/WAW stalls.
module regfile_wb_arb
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = XLEN
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_hold,
  input  logic                      i_issue_valid,
  input  logic [ADDR_W-1:0]         i_issue_addr,
  output logic [ADDR_W-1:0]         o_rd_addr,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_rd_wren,
  output logic [NUM_REGS-1:0]       o_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]    r_ptr;
  wb_req_t             r_wb;
  logic                r_wren;
  logic [NUM_REGS-1:0] r_busy;

  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_any;
  logic [PTR_W-1:0]    w_idx;
  logic [PTR_W-1:0]    w_ptr_nxt;
  wb_req_t             w_sel;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Hold and reset suppress the requests themselves, so no grant can escape.
  assign w_req = (i_hold || i_rst) ? '0 : i_req_valid;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  assign o_req_ready = w_gnt;

  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_any      = 1'b1;
        w_idx      = PTR_W'(k);
        w_sel.addr = i_req_addr[k*ADDR_W +: ADDR_W];
        w_sel.data = i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_ptr_nxt = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  // Set is applied after clear: a same-cycle issue means a newer producer owns the register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_any && (w_sel.addr != '0)) w_busy_nxt[w_sel.addr] = 1'b0;
    if (i_issue_valid && (i_issue_addr != '0)) w_busy_nxt[i_issue_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr  <= '0;
      r_wb   <= '0;
      r_wren <= 1'b0;
      r_busy <= '0;
    end else begin
      if (w_any) begin
        r_ptr <= w_ptr_nxt;
        r_wb  <= w_sel;
      end
      r_wren <= w_any && (w_sel.addr != '0);
      r_busy <= w_busy_nxt;
    end
  end

  assign o_rd_addr = r_wb.addr;
  assign o_rd_data = r_wb.data;
  assign o_rd_wren = r_wren;
  assign o_busy    = r_busy;

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-back arbiter and scoreboard for the 32 x 32-bit integer register file. It shares the register file's single write port between NUM_REQ producers (ALU, load unit, multi-cycle mul/div) using round-robin arbitration with valid/ready handshakes, and drives one registered write per cycle. It also keeps a per-register busy scoreboard that the issue stage uses for RAW/WAW stalls. It sits between the execute/memory producers and the register file write port.

## Interface
- NUM_REQ, 3, number of write-back requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- i_clk  in  1  global clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  NUM_REQ  requester k has a write pending
- i_req_addr  in  NUM_REQ*ADDR_W  destination address, requester k at bits [k*ADDR_W +: ADDR_W]
- i_req_data  in  NUM_REQ*DATA_W  write data, requester k at bits [k*DATA_W +: DATA_W]
- o_req_ready  out  NUM_REQ  one-hot grant; transfer occurs when valid & ready
- i_hold  in  1  pipeline freeze; blocks all grants while high
- i_issue_valid  in  1  an instruction with a destination register issues this cycle
- i_issue_addr  in  ADDR_W  destination of the issuing instruction
- o_rd_addr  out  ADDR_W  to register file write address
- o_rd_data  out  DATA_W  to register file write data
- o_rd_wren  out  1  to register file write enable
- o_busy  out  32  scoreboard; bit r = write to xr outstanding; bit 0 constant 0

## Operation
- Arbitration: combinational round-robin over i_req_valid, starting at pointer rr_ptr and wrapping modulo NUM_REQ. At most one o_req_ready bit is high. o_req_ready is all-zero when i_hold=1 or no valid request is present.
- o_req_ready[k] never depends on requester k's own ready. Once a requester asserts valid, it keeps valid/addr/data stable until granted.
- Pointer: on a grant to k, rr_ptr <= (k+1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
- Output stage: on a grant to k, the next edge loads o_rd_addr/o_rd_data from requester k and sets o_rd_wren=1 if addr != 0, 0 otherwise. Writes to x0 are accepted (ready asserted) and dropped. With no grant, o_rd_wren <= 0 and addr/data hold their previous values.
- Scoreboard set: i_issue_valid with i_issue_addr != 0 sets busy[i_issue_addr] at the next edge. Issue is independent of i_hold; the issue stage gates it.
- Scoreboard clear: a granted write to r != 0 clears busy[r] at the edge that loads the output register.
- Same-cycle set and clear on the same r: set wins and busy stays 1, because a newer producer exists.
- Set/clear on different registers in the same cycle: both take effect.
- busy[0] is always 0. A write to a register that is not busy is legal and leaves busy at 0.
- Reset: rr_ptr=0, o_busy=0, o_rd_wren=0, o_rd_addr=0, o_rd_data=0. Any request or issue presented in the reset cycle is ignored, and o_req_ready is forced to 0 while i_rst=1.

## Timing
- Arbitration latency: grant is combinational in the same cycle as valid.
- Write latency: a grant in cycle N gives o_rd_* valid in cycle N+1. The register file captures the data at the end of cycle N+1. busy[r] reads 0 starting in cycle N+1.
- Throughput: one write per cycle. With all requesters continuously valid, grants rotate 0,1,2,0,...
- Worst-case wait for a continuously valid requester: NUM_REQ-1 cycles (while i_hold=0).
- Reset mid-stream: an in-flight output-register write is discarded (wren=0 the cycle after reset), and the scoreboard clears.

## Structure
- Shared package regfile_pkg holds XLEN=32, REG_ADDR_W=5, NUM_REGS=32, NUM_WB_REQ=3, and a wb_req_t struct {addr, data}. The register file and this block both import it.
- One sub-module: rr_arbiter (parameter N; inputs req, ptr; output one-hot gnt). It is purely combinational and reusable for the memory-port arbiter.
- Top holds rr_ptr, the output register, and the 32-bit scoreboard. Target size is about 200 lines.

## Test plan
- Reset, then idle: o_busy=0, o_rd_wren=0 and o_req_ready=000 for 10 cycles.
- All three valid every cycle with addrs 1/2/3 and data A/B/C: ready sequence 001,010,100,001; wren writes x1=A, x2=B, x3=C in cycles N+1..N+3.
- Issue x5 in cycle 0 gives busy[5]=1 in cycle 1. Requester 1 writes x5 in cycle 3 with issue of x5 in the same cycle, so busy[5] stays 1. A second write in cycle 5 gives busy[5]=0 in cycle 6.
- Requester 0 writes x0=0xDEADBEEF: ready=1, o_rd_wren stays 0, and busy[0] stays 0.
- i_hold=1 for 3 cycles with requesters 0 and 2 valid: ready=000 and rr_ptr frozen. After release, requester 0 is granted first if rr_ptr=0.
- i_rst pulsed the cycle after a grant to x7: o_rd_wren=0 next cycle, o_busy=0, and rr_ptr=0.
